// File: rtl/display_pkg.sv
// Shared constants for the display path: active-high segment patterns ({g,f,e,d,c,b,a})
// and the conversion state type.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

endpackage

// File: rtl/display_bcd_seq_if.sv
// Load/result bus of the display driver: the master side launches conversions,
// the slave side reports busy/done and the registered BCD/segment results.
interface display_bcd_seq_if #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
);
    logic                  load;
    logic [DATA_W-1:0]     binary;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   seg;
    logic                  overflow;

    modport master (output load, binary, input busy, done, bcd, seg, overflow);
    modport slave  (input load, binary, output busy, done, bcd, seg, overflow);
endinterface

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-high 7-segment pattern; blank flag or values 10..15 give all-off.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end
endmodule

// File: rtl/display_bcd_seq.sv
// Sequential double-dabble binary to 7-segment driver, one input bit per clock.
// Define DISPLAY_SIGNED_EN to treat binary as two's complement and show a leading minus sign.
//   state  | meaning
//   IDLE   | waiting for load; results held
//   SHIFT  | one dabble+shift step per clock, MSB first
//   ENCODE | register bcd/seg/overflow, pulse done next cycle
module display_bcd_seq
    import display_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int DIGITS         = 5,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input logic              clock,
    input logic              reset,
    display_bcd_seq_if.slave bus
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;
    localparam logic [SW-1:0] SEG_RST = (SEG_ACTIVE_LOW != 0) ? {SW{1'b1}} : {SW{1'b0}};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [BW-1:0]     acc_q, acc_d, adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_acc_q, ovf_acc_d;
    logic [BW-1:0]     bcd_q, bcd_d, enc_bcd;
    logic [SW-1:0]     seg_q, seg_d, enc_seg;
    logic              ovf_q, ovf_d, enc_ovf;
    logic              done_q, done_d;
    logic [DIGITS-1:0] blank;
    logic [6:0]        dec_seg [DIGITS];
    logic [6:0]        seg_pat;
    int                top_nz;
`ifdef DISPLAY_SIGNED_EN
    logic              neg_q, neg_d;
    int                minus_pos;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_seg7 u_dec (.digit(acc_q[4*g +: 4]), .blank(blank[g]), .seg(dec_seg[g]));
    end

    always_comb begin
        enc_ovf = ovf_acc_q;
        top_nz  = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] != 4'd0) top_nz = k;
        end
`ifdef DISPLAY_SIGNED_EN
        // top digit is reserved for the sign, so any magnitude there is out of range
        if (acc_q[BW-1 -: 4] != 4'd0) enc_ovf = 1'b1;
        minus_pos = (BLANK_LZ != 0) ? top_nz + 1 : DIGITS - 1;
`endif
        for (int k = 0; k < DIGITS; k++) begin
            blank[k] = enc_ovf || ((BLANK_LZ != 0) && (k > top_nz));
        end
`ifdef DISPLAY_SIGNED_EN
        blank[DIGITS-1] = 1'b1;
`endif
    end

    always_comb begin
        seg_pat = SEG_BLANK;
        enc_bcd = enc_ovf ? '0 : acc_q;
        enc_seg = '0;
        for (int k = 0; k < DIGITS; k++) begin
            seg_pat = dec_seg[k];
            if (enc_ovf) seg_pat = (k == 0) ? SEG_E : SEG_BLANK;
`ifdef DISPLAY_SIGNED_EN
            else if (neg_q && (k == minus_pos)) seg_pat = SEG_MINUS;
`endif
            enc_seg[7*k +: 7] = (SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
        end
    end

    always_comb begin
        adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        seg_d     = seg_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
`ifdef DISPLAY_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            IDLE: begin
                // done_q still high means this is the done cycle, where load is refused
                if (bus.load && !done_q) begin
                    sh_d      = bus.binary;
`ifdef DISPLAY_SIGNED_EN
                    neg_d     = bus.binary[DATA_W-1];
                    if (bus.binary[DATA_W-1]) sh_d = -bus.binary;
`endif
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {adj[BW-2:0], sh_q[DATA_W-1]};
                sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (adj[BW-1]) ovf_acc_d = 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) state_d = ENCODE;
            end
            ENCODE: begin
                bcd_d   = enc_bcd;
                seg_d   = enc_seg;
                ovf_d   = enc_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            seg_q     <= SEG_RST;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef DISPLAY_SIGNED_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
`ifdef DISPLAY_SIGNED_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign bus.busy     = (state_q != IDLE) || done_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.seg      = seg_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_display_bcd_seq.sv
// Bench for display_bcd_seq: 5-digit and 4-digit instances fed identical stimulus,
// compared every cycle against an arithmetic reference model.
module tb_display_bcd_seq;
    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        load   = 1'b0;
    logic [15:0] binary = '0;
    int          tests  = 0;
    int          fails  = 0;
    int          n_done = 0;

    always #5 clk = ~clk;

    display_bcd_seq_if #(.DATA_W(16), .DIGITS(5)) bus5 ();
    display_bcd_seq_if #(.DATA_W(16), .DIGITS(4)) bus4 ();
    assign bus5.load   = load;
    assign bus5.binary = binary;
    assign bus4.load   = load;
    assign bus4.binary = binary;

    display_bcd_seq #(.DATA_W(16), .DIGITS(5), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1))
        dut5 (.clock(clk), .reset(rst), .bus(bus5));
    display_bcd_seq #(.DATA_W(16), .DIGITS(4), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1))
        dut4 (.clock(clk), .reset(rst), .bus(bus4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Display rules from plain decimal arithmetic; active-low patterns, leading zeros blanked.
    function automatic void ref_conv(input logic [15:0] v, input int nd,
                                     output logic [19:0] e_bcd, output logic [34:0] e_seg,
                                     output logic e_ovf);
        logic [6:0] tab [10];
        int d [5];
        int mag, md, lim, p, top;
        bit neg;
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        neg = 1'b0;
        mag = int'(v);
        md  = nd;
`ifdef DISPLAY_SIGNED_EN
        md = nd - 1;
        if (v[15]) begin
            neg = 1'b1;
            mag = 65536 - int'(v);
        end
`endif
        lim = 1;
        for (int k = 0; k < md; k++) lim *= 10;
        e_ovf = (mag >= lim);
        e_bcd = '0;
        e_seg = '0;
        for (int k = 0; k < nd; k++) e_seg[7*k +: 7] = 7'h7F;
        if (e_ovf) begin
            e_seg[6:0] = ~7'h79;
            return;
        end
        top = 0;
        p   = 1;
        for (int k = 0; k < md; k++) begin
            d[k] = (mag / p) % 10;
            p   *= 10;
            e_bcd[4*k +: 4] = 4'(d[k]);
            if (d[k] != 0) top = k;
        end
        for (int k = 0; k <= top; k++) e_seg[7*k +: 7] = ~tab[d[k]];
        if (neg) e_seg[7*(top+1) +: 7] = ~7'h40;
    endfunction

    // Edge-count model: conversion accepted when idle, results appear DATA_W+1 edges later.
    int          m_n    = -1;
    bit          m_done = 1'b0;
    logic [15:0] m_val  = '0;
    logic [19:0] e_bcd5 = '0;
    logic [34:0] e_seg5 = '1;
    logic        e_ovf5 = 1'b0;
    logic [19:0] e_bcd4 = '0;
    logic [34:0] e_seg4 = '1;
    logic        e_ovf4 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = -1; m_done = 1'b0;
            e_bcd5 = '0; e_seg5 = '1; e_ovf5 = 1'b0;
            e_bcd4 = '0; e_seg4 = '1; e_ovf4 = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_n < 0) begin
            if (load) begin
                m_val = binary;
                m_n   = 0;
            end
        end else begin
            m_n++;
            if (m_n == 17) begin
                ref_conv(m_val, 5, e_bcd5, e_seg5, e_ovf5);
                ref_conv(m_val, 4, e_bcd4, e_seg4, e_ovf4);
                m_done = 1'b1;
                m_n    = -1;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy5", 64'(bus5.busy), 64'((m_n >= 0) || m_done));
        chk("done5", 64'(bus5.done), 64'(m_done));
        chk("bcd5",  64'(bus5.bcd), 64'(e_bcd5));
        chk("seg5",  64'(bus5.seg), 64'(e_seg5));
        chk("ovf5",  64'(bus5.overflow), 64'(e_ovf5));
        chk("busy4", 64'(bus4.busy), 64'((m_n >= 0) || m_done));
        chk("done4", 64'(bus4.done), 64'(m_done));
        chk("bcd4",  64'(bus4.bcd), 64'(e_bcd4[15:0]));
        chk("seg4",  64'(bus4.seg), 64'(e_seg4[27:0]));
        chk("ovf4",  64'(bus4.overflow), 64'(e_ovf4));
        if (bus5.done === 1'b1) n_done++;
    end

    // Caller is at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic convert(input logic [15:0] v, input int extra, output int lat);
        load   = 1'b1;
        binary = v;
        @(negedge clk);
        load   = 1'b0;
        binary = 16'($urandom);
        lat    = 0;
        while (bus5.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (extra > 0 && lat == extra) begin
                load   = 1'b1;
                binary = 16'd7;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] corner [8];
        int lat, n0;
        corner = '{16'd0, 16'd9, 16'd10, 16'd999, 16'd9999, 16'd10000, 16'd32768, 16'd65535};

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus5.busy), 64'(0));
        chk("rst_bcd",  64'(bus5.bcd), 64'(0));
        chk("rst_seg",  64'(bus5.seg), 64'h7_FFFF_FFFF);
        chk("rst_ovf",  64'(bus5.overflow), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        convert(16'd1234, 0, lat);
        chk("lat_1234", 64'(lat), 64'(17));
        chk("bcd_1234", 64'(bus5.bcd), 64'(20'h01234));
        chk("seg_1234", 64'(bus5.seg), 64'({7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
        load   = 1'b1;
        binary = 16'd5;
        @(negedge clk);
        chk("done_cycle_load_refused", 64'(bus5.busy), 64'(0));

        convert(16'd0, 0, lat);
        chk("lat_back_to_back", 64'(lat), 64'(17));
        chk("bcd_0", 64'(bus5.bcd), 64'(0));
        chk("seg_0", 64'(bus5.seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
        chk("ovf_0", 64'(bus5.overflow), 64'(0));

        @(negedge clk);
        n0 = n_done;
        convert(16'd65535, 5, lat);
        chk("lat_65535", 64'(lat), 64'(17));
        chk("bcd_65535", 64'(bus5.bcd), 64'(20'h65535));
        chk("seg_65535", 64'(bus5.seg), 64'({7'h02, 7'h12, 7'h12, 7'h30, 7'h12}));
        repeat (25) @(negedge clk);
        chk("single_done", 64'(n_done), 64'(n0 + 1));
        chk("hold_65535", 64'(bus5.bcd), 64'(20'h65535));

        convert(16'd10000, 0, lat);
        chk("ovf4_10000", 64'(bus4.overflow), 64'(1));
        chk("bcd4_10000", 64'(bus4.bcd), 64'(0));
        chk("seg4_10000", 64'(bus4.seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h06}));
        chk("bcd5_10000", 64'(bus5.bcd), 64'(20'h10000));

        @(negedge clk);
        n0     = n_done;
        load   = 1'b1;
        binary = 16'd42;
        @(negedge clk);
        load   = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(bus5.busy), 64'(0));
        chk("abort_done", 64'(bus5.done), 64'(0));
        chk("abort_bcd",  64'(bus5.bcd), 64'(0));
        chk("abort_seg",  64'(bus5.seg), 64'h7_FFFF_FFFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_no_done", 64'(n_done), 64'(n0));
        convert(16'd42, 0, lat);
        chk("lat_42", 64'(lat), 64'(17));
        chk("bcd_42", 64'(bus5.bcd), 64'(20'h00042));
        chk("seg_42", 64'(bus5.seg), 64'({7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}));

        @(negedge clk);
        convert(16'hFFD6, 0, lat);
`ifdef DISPLAY_SIGNED_EN
        chk("bcd_neg42", 64'(bus5.bcd), 64'(20'h00042));
        chk("seg_neg42", 64'(bus5.seg), 64'({7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h24}));
`else
        chk("bcd_65494", 64'(bus5.bcd), 64'(20'h65494));
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) binary = corner[$urandom_range(0, 7)];
            else binary = 16'($urandom);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
